// File: rtl/barrett_arbiter.sv
// Two request ports share one 3-stage Barrett reducer. Grants are round-robin and
// gated by per-port credits. Modulus reloads wait until the pipeline has drained.
// Defining BARRETT_ARB_STATS_EN adds saturating per-port issue counters.

module barrett_reduce #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic [2*WIDTH-1:0] x,
   input  logic [WIDTH-1:0]   q,
   input  logic [WIDTH+1:0]   mu,
   output logic [WIDTH-1:0]   r
);
   logic [WIDTH+1:0] qhat_s1;
   logic [WIDTH+1:0] x_lo_s1;
   logic [WIDTH+1:0] rem_s2;
   logic [WIDTH+1:0] qq;
   logic [WIDTH+1:0] rem_a;
   logic [WIDTH+1:0] q_ext;
   logic [WIDTH-1:0] rem_fin;

   // The estimate undershoots by at most two, so the remainder is below 3q and
   // fits in WIDTH+2 bits. Only the low bits of x and qhat*q are needed.
   assign q_ext = {2'b00, q};
   assign qq    = qhat_s1 * q_ext;

   always_comb begin
      rem_a   = (rem_s2 >= q_ext) ? rem_s2 - q_ext : rem_s2;
      rem_fin = (rem_a >= q_ext) ? WIDTH'(rem_a - q_ext) : rem_a[WIDTH-1:0];
   end

   // NOTE: datapath registers are not reset; validity travels in the tag pipeline.
   always_ff @(posedge clk) begin
      qhat_s1 <= (WIDTH+2)'(({{(WIDTH+2){1'b0}}, x} * {{(2*WIDTH){1'b0}}, mu}) >> (2*WIDTH));
      x_lo_s1 <= x[WIDTH+1:0];
      rem_s2  <= x_lo_s1 - qq;
      r       <= rem_fin;
   end
endmodule

module barrett_arb_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign valid = (count != '0);
   assign data  = valid ? mem[rd_ptr] : '0;
endmodule

module barrett_arbiter #(
   parameter int          WIDTH   = 24,
   parameter int          DEPTH   = 4,
   parameter int unsigned Q_INIT  = 8380417,
   parameter int unsigned MU_INIT = 33587228
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [WIDTH-1:0]   cfg_q,
   input  logic [WIDTH+1:0]   cfg_mu,
   output logic               cfg_busy,
   input  logic               a_req_valid,
   output logic               a_req_ready,
   input  logic [2*WIDTH-1:0] a_req_prod,
   output logic               a_rsp_valid,
   input  logic               a_rsp_ready,
   output logic [WIDTH-1:0]   a_rsp_data,
   input  logic               b_req_valid,
   output logic               b_req_ready,
   input  logic [2*WIDTH-1:0] b_req_prod,
   output logic               b_rsp_valid,
   input  logic               b_rsp_ready,
`ifdef BARRETT_ARB_STATS_EN
   output logic [15:0]        a_issue_cnt,
   output logic [15:0]        b_issue_cnt,
`endif
   output logic [WIDTH-1:0]   b_rsp_data
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_t;

   state_t           state;
   state_t           state_next;
   logic             run;
   logic             load;
   logic [WIDTH-1:0] q_act,  q_shadow;
   logic [WIDTH+1:0] mu_act, mu_shadow;
   logic [CW-1:0]    a_credit, b_credit;
   logic             last_b;
   logic             elig_a, elig_b, xfer_a, xfer_b, issue;
   logic             pop_a, pop_b;
   logic [2:0]       tag_vld, tag_port;
   logic [1:0]       in_flight;
   logic [WIDTH-1:0] red_out;
   logic             a_fifo_valid, b_fifo_valid;
   logic [WIDTH-1:0] a_fifo_data,  b_fifo_data;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   // NOTE: next state defaults to the current state so no path leaves it unassigned.
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (cfg_we)            state_next = DRAIN;
         DRAIN:   if (in_flight == 2'd0) state_next = LOAD;
         LOAD:                           state_next = RUN;
         default:                        state_next = RUN;
      endcase
   end

   always_comb begin
      run      = (state == RUN);
      load     = (state == LOAD);
      cfg_busy = !rst && (state != RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_act     <= WIDTH'(Q_INIT);
         mu_act    <= (WIDTH+2)'(MU_INIT);
         q_shadow  <= WIDTH'(Q_INIT);
         mu_shadow <= (WIDTH+2)'(MU_INIT);
      end else begin
         if (run && cfg_we) begin
            q_shadow  <= cfg_q;
            mu_shadow <= cfg_mu;
         end
         if (load) begin
            q_act  <= q_shadow;
            mu_act <= mu_shadow;
         end
      end
   end

   // On a tie, grant the port that was not granted last.
   assign elig_a      = a_req_valid && (a_credit != '0) && run;
   assign elig_b      = b_req_valid && (b_credit != '0) && run;
   assign a_req_ready = !rst && elig_a && (!elig_b || last_b);
   assign b_req_ready = !rst && elig_b && (!elig_a || !last_b);
   assign xfer_a      = a_req_ready;
   assign xfer_b      = b_req_ready;
   assign issue       = xfer_a || xfer_b;

   always_ff @(posedge clk) begin
      if (rst)         last_b <= 1'b1;
      else if (xfer_a) last_b <= 1'b0;
      else if (xfer_b) last_b <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_credit <= CW'(DEPTH);
         b_credit <= CW'(DEPTH);
      end else begin
         case ({xfer_a, pop_a})
            2'b10:   a_credit <= a_credit - CW'(1);
            2'b01:   a_credit <= a_credit + CW'(1);
            default: a_credit <= a_credit;
         endcase
         case ({xfer_b, pop_b})
            2'b10:   b_credit <= b_credit - CW'(1);
            2'b01:   b_credit <= b_credit + CW'(1);
            default: b_credit <= b_credit;
         endcase
      end
   end

   barrett_reduce #(.WIDTH(WIDTH)) u_reduce (
      .clk (clk),
      .x   (xfer_b ? b_req_prod : a_req_prod),
      .q   (q_act),
      .mu  (mu_act),
      .r   (red_out)
   );

   // The tag pipeline mirrors the reducer so each result knows its port.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld <= '0;
      end else begin
         tag_vld  <= {tag_vld[1:0], issue};
         tag_port <= {tag_port[1:0], xfer_b};
      end
   end

   assign in_flight = 2'(tag_vld[0]) + 2'(tag_vld[1]) + 2'(tag_vld[2]);

   barrett_arb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst       (rst),
      .push      (tag_vld[2] && !tag_port[2]),
      .push_data (red_out),
      .pop       (pop_a),
      .valid     (a_fifo_valid),
      .data      (a_fifo_data)
   );

   barrett_arb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst       (rst),
      .push      (tag_vld[2] && tag_port[2]),
      .push_data (red_out),
      .pop       (pop_b),
      .valid     (b_fifo_valid),
      .data      (b_fifo_data)
   );

   assign a_rsp_valid = !rst && a_fifo_valid;
   assign b_rsp_valid = !rst && b_fifo_valid;
   assign a_rsp_data  = rst ? '0 : a_fifo_data;
   assign b_rsp_data  = rst ? '0 : b_fifo_data;
   assign pop_a       = a_rsp_valid && a_rsp_ready;
   assign pop_b       = b_rsp_valid && b_rsp_ready;

`ifdef BARRETT_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         a_issue_cnt <= '0;
         b_issue_cnt <= '0;
      end else begin
         if (xfer_a && (a_issue_cnt != 16'hFFFF)) a_issue_cnt <= a_issue_cnt + 16'd1;
         if (xfer_b && (b_issue_cnt != 16'hFFFF)) b_issue_cnt <= b_issue_cnt + 16'd1;
      end
   end
`else
   // Issue counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_barrett_arbiter.sv
// Self-checking bench for barrett_arbiter: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.

module tb_barrett_arbiter;
   localparam int WIDTH = 24;
   localparam int DEPTH = 4;
   localparam longint unsigned Q0 = 8380417;
   // Only the low WIDTH+2 bits of floor(2^48/3329) fit the port; operands below 3q reduce correctly anyway.
   localparam logic [WIDTH+1:0] MU_3329 = (WIDTH+2)'((64'd1 << 48) / 64'd3329);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cfg_we = 1'b0;
   logic [WIDTH-1:0]   cfg_q = '0;
   logic [WIDTH+1:0]   cfg_mu = '0;
   logic               cfg_busy;
   logic               a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic               a_req_ready, b_req_ready;
   logic [2*WIDTH-1:0] a_req_prod = '0, b_req_prod = '0;
   logic               a_rsp_valid, b_rsp_valid;
   logic               a_rsp_ready = 1'b1, b_rsp_ready = 1'b1;
   logic [WIDTH-1:0]   a_rsp_data, b_rsp_data;
`ifdef BARRETT_ARB_STATS_EN
   logic [15:0]        a_issue_cnt, b_issue_cnt;
`endif

   always #5 clk = ~clk;

   barrett_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_q       (cfg_q),
      .cfg_mu      (cfg_mu),
      .cfg_busy    (cfg_busy),
      .a_req_valid (a_req_valid),
      .a_req_ready (a_req_ready),
      .a_req_prod  (a_req_prod),
      .a_rsp_valid (a_rsp_valid),
      .a_rsp_ready (a_rsp_ready),
      .a_rsp_data  (a_rsp_data),
      .b_req_valid (b_req_valid),
      .b_req_ready (b_req_ready),
      .b_req_prod  (b_req_prod),
      .b_rsp_valid (b_rsp_valid),
      .b_rsp_ready (b_rsp_ready),
`ifdef BARRETT_ARB_STATS_EN
      .a_issue_cnt (a_issue_cnt),
      .b_issue_cnt (b_issue_cnt),
`endif
      .b_rsp_data  (b_rsp_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: outstanding work per port is whatever is still in flight
   // or waiting in that port's response queue.
   typedef struct {
      bit              port;
      longint unsigned data;
      int              due;
   } flight_t;

   flight_t         flight[$];
   longint unsigned rsp_q_a[$];
   longint unsigned rsp_q_b[$];
   int              cyc = 0;
   bit              m_last_b = 1'b1;
   int              m_state = 0;
   longint unsigned m_q = Q0;
   longint unsigned m_q_shadow = Q0;

   function automatic int outstanding(input bit p);
      int n = p ? rsp_q_b.size() : rsp_q_a.size();
      foreach (flight[i]) if (flight[i].port == p) n++;
      return n;
   endfunction

   function automatic bit m_elig(input bit p);
      return !rst && (m_state == 0) && (p ? b_req_valid : a_req_valid) && (outstanding(p) < DEPTH);
   endfunction

   function automatic bit m_grant(input bit p);
      bit ea = m_elig(1'b0);
      bit eb = m_elig(1'b1);
      if (p) return eb && (!ea || !m_last_b);
      return ea && (!eb || m_last_b);
   endfunction

   task automatic model_step();
      bit ga   = m_grant(1'b0);
      bit gb   = m_grant(1'b1);
      bit pa   = !rst && (rsp_q_a.size() > 0) && a_rsp_ready;
      bit pb   = !rst && (rsp_q_b.size() > 0) && b_rsp_ready;
      int n_fl = flight.size();
      cyc++;
      if (rst) begin
         flight.delete();
         rsp_q_a.delete();
         rsp_q_b.delete();
         m_state  = 0;
         m_last_b = 1'b1;
         m_q      = Q0;
         return;
      end
      if (pa) void'(rsp_q_a.pop_front());
      if (pb) void'(rsp_q_b.pop_front());
      while (flight.size() > 0 && flight[0].due == cyc) begin
         flight_t f = flight.pop_front();
         if (f.port) rsp_q_b.push_back(f.data);
         else        rsp_q_a.push_back(f.data);
      end
      if (ga) begin
         flight.push_back('{port: 1'b0, data: a_req_prod % m_q, due: cyc + 3});
         m_last_b = 1'b0;
      end
      if (gb) begin
         flight.push_back('{port: 1'b1, data: b_req_prod % m_q, due: cyc + 3});
         m_last_b = 1'b1;
      end
      case (m_state)
         0: if (cfg_we) begin
               m_state    = 1;
               m_q_shadow = cfg_q;
            end
         1: if (n_fl == 0) m_state = 2;
         default: begin
               m_q     = m_q_shadow;
               m_state = 0;
            end
      endcase
   endtask

   task automatic compare_outputs();
      bit va = !rst && (rsp_q_a.size() > 0);
      bit vb = !rst && (rsp_q_b.size() > 0);
      check("a_req_ready", a_req_ready, m_grant(1'b0));
      check("b_req_ready", b_req_ready, m_grant(1'b1));
      check("a_rsp_valid", a_rsp_valid, va);
      check("b_rsp_valid", b_rsp_valid, vb);
      check("cfg_busy", cfg_busy, !rst && (m_state != 0));
      if (va) check("a_rsp_data", a_rsp_data, rsp_q_a[0]);
      if (vb) check("b_rsp_data", b_rsp_data, rsp_q_b[0]);
      if (rst) begin
         check("a_rsp_data_rst", a_rsp_data, 0);
         check("b_rsp_data_rst", b_rsp_data, 0);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      compare_outputs();
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] got_q[$];

   task automatic tick_collect();
      tick();
      if (a_rsp_valid) got_q.push_back(a_rsp_data);
   endtask

   initial begin
      int n;
      bit got;

      // Reset: requester must be refused while rst is high.
      a_req_valid = 1'b1;
      repeat (2) tick();
      check("rst_a_req_ready", a_req_ready, 0);
      a_req_valid = 1'b0;
      rst = 1'b0;
      tick();
      check("rst_cfg_busy", cfg_busy, 0);
      check("rst_a_rsp_valid", a_rsp_valid, 0);
      check("rst_b_rsp_data", b_rsp_data, 0);

      // (q-1)^2 mod q = 1, visible four cycles after valid is raised.
      a_req_prod  = 48'd8380416 * 48'd8380416;
      a_req_valid = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 12) begin
         tick();
         n++;
         if (n == 1) a_req_valid = 1'b0;
         if (a_rsp_valid) got = 1'b1;
      end
      check("req024_latency", n, 4);
      check("req024_data", a_rsp_data, 1);
      repeat (3) tick();

      // Both ports busy: a was granted last, so b leads and grants alternate.
      a_req_prod  = 48'd0;
      b_req_prod  = 48'd8380417;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("req025_a_grant", a_req_ready, i % 2);
         check("req025_b_grant", b_req_ready, (i + 1) % 2);
      end
      tick();
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      repeat (6) tick();

      // b responses back-pressured: credits run out after DEPTH transfers.
      b_rsp_ready = 1'b0;
      b_req_prod  = 48'd5;
      b_req_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (b_req_ready) n++;
      end
      check("req026_fill", n, DEPTH);
      check("req026_stall", b_req_ready, 0);
      tick();
      b_rsp_ready = 1'b1;
      tick();
      b_rsp_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b_req_ready) n++;
      end
      check("req026_refill", n, 1);
      tick();
      b_req_valid = 1'b0;
      b_rsp_ready = 1'b1;
      repeat (10) tick();

      // Reload q while three results are in flight; they keep the old modulus.
      got_q.delete();
      a_req_valid = 1'b1;
      a_req_prod  = 48'd100;
      tick_collect();
      a_req_prod  = 48'd8380418;
      tick_collect();
      a_req_prod  = 48'd41902092;
      tick_collect();
      a_req_valid = 1'b0;
      cfg_we = 1'b1;
      cfg_q  = 24'd3329;
      cfg_mu = MU_3329;
      tick_collect();
      cfg_we = 1'b0;
      check("req027_busy", cfg_busy, 1);
      a_req_valid = 1'b1;
      a_req_prod  = 48'd3330;
      n = 0;
      while (got_q.size() < 4 && n < 40) begin
         tick_collect();
         n++;
      end
      a_req_valid = 1'b0;
      check("req027_count", got_q.size(), 4);
      if (got_q.size() >= 4) begin
         check("req027_old0", got_q[0], 100);
         check("req027_old1", got_q[1], 1);
         check("req027_old2", got_q[2], 7);
         check("req027_new", got_q[3], 1);
      end
      repeat (8) tick();

      // Reset with two results in flight: they must vanish.
      a_req_valid = 1'b1;
      a_req_prod  = 48'd3331;
      tick();
      tick();
      a_req_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      repeat (8) begin
         tick();
         if (a_rsp_valid || b_rsp_valid) n++;
      end
      check("req028_no_rsp", n, 0);
      a_rsp_ready = 1'b0;
      a_req_prod  = 48'd8380419;
      a_req_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (a_req_ready) n++;
      end
      check("req028_credits", n, DEPTH);
      tick();
      a_req_valid = 1'b0;
      check("req028_rsp_valid", a_rsp_valid, 1);
      check("req028_rsp_data", a_rsp_data, 2);
      a_rsp_ready = 1'b1;
      repeat (8) tick();

`ifdef BARRETT_ARB_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_req_prod  = 48'd12345;
      a_req_valid = 1'b1;
      n = 0;
      for (int k = 0; n < 1000 && k < 2000; k++) begin
         @(negedge clk);
         if (a_req_ready) n++;
      end
      tick();
      check("stats_a_mid", a_issue_cnt, 1000);
      for (int k = 0; n < 65540 && k < 90000; k++) begin
         @(negedge clk);
         if (a_req_ready) n++;
      end
      tick();
      a_req_valid = 1'b0;
      check("stats_a_sat", a_issue_cnt, 65535);
      check("stats_b_zero", b_issue_cnt, 0);
      repeat (8) tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
